// File: rtl/sram_responder_if.sv
// sram_responder_if
//   Control and status bundle for the synchronous SRAM responder. The
//   bidirectional data bus stays a plain inout on the responder so that
//   tri-state resolution happens on an ordinary net.
//
//   Signals (slave = responder side):
//     addr[17:0]         word address
//     wre                write enable, active-low
//     oute               output enable, active-low
//     hb_mask            high-byte enable (data[15:8]), active-low
//     lb_mask            low-byte enable (data[7:0]), active-low
//     chip_en            chip select, active-low
//     rd_valid           high while read data is driven on data
//     access_count[15:0] accepted reads plus writes, wrapping
//     err_conflict       sticky protocol-error flag
interface sram_responder_if;
    logic [17:0] addr;
    logic        wre;
    logic        oute;
    logic        hb_mask;
    logic        lb_mask;
    logic        chip_en;
    logic        rd_valid;
    logic [15:0] access_count;
    logic        err_conflict;

    modport master (
        output addr, wre, oute, hb_mask, lb_mask, chip_en,
        input  rd_valid, access_count, err_conflict
    );

    modport slave (
        input  addr, wre, oute, hb_mask, lb_mask, chip_en,
        output rd_valid, access_count, err_conflict
    );
endinterface

// File: rtl/sram_responder.sv
// sram_responder
//   Behavioural synchronous SRAM with byte masks and a fixed read latency.
//   Writes take priority over reads; reads are captured into a READ_LAT-deep
//   pipeline and presented on the tri-state data bus for exactly one cycle,
//   gated by the live chip_en/oute/wre pins and the byte masks captured with
//   the read.
//
//   Parameters:
//     DEPTH_LOG2  log2 of the number of stored 16-bit words (default 12)
//     READ_LAT    posedges from read sample to data drive, legal 1..4 (default 2)
//
//   Ports:
//     clock       sole clock, rising edge
//     reset       asynchronous, active-low
//     bus         sram_responder_if.slave (address, strobes, status)
//     data[15:0]  bidirectional data, high-Z when not driven
//
//   Optional feature macro: SRAM_RESPONDER_CONFLICT_EN
//     defined   -> err_conflict latches bus-contention conditions until reset
//     undefined -> no checking logic, err_conflict tied low
module sram_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int READ_LAT   = 2
) (
    input  logic              clock,
    input  logic              reset,
    sram_responder_if.slave   bus,
    inout  wire  [15:0]       data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LAST  = READ_LAT - 1;

    logic [15:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  wr_acc;
    logic                  rd_acc;

    logic [READ_LAT-1:0]   vld_q;
    logic [READ_LAT-1:0]   vld_d;
    logic [15:0]           dat_q [READ_LAT];
    logic [READ_LAT-1:0]   hbm_q;
    logic [READ_LAT-1:0]   lbm_q;

    logic [15:0]           cnt_q;
    logic [15:0]           cnt_d;

    logic                  out_vld;
    logic                  rd_gate;
    logic                  drive_hi;
    logic                  drive_lo;

    // Upper address bits are intentionally ignored (address wrap-around).
    wire unused_addr = ^{1'b0, bus.addr};

    assign idx    = bus.addr[DEPTH_LOG2-1:0];
    assign wr_acc = ~bus.chip_en & ~bus.wre;
    assign rd_acc = ~bus.chip_en &  bus.wre & ~bus.oute;

    // Storage: no reset, contents survive reset assertion.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            if (!bus.hb_mask) mem_q[idx][15:8] <= data[15:8];
            if (!bus.lb_mask) mem_q[idx][7:0]  <= data[7:0];
        end
    end

    // Every edge shifts the pipeline; cycles without a read insert a bubble.
    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = rd_acc;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Payload needs no reset; it is qualified by vld_q. The memory word is
    // sampled before this edge's write lands, so a read sees writes up to
    // the previous edge only.
    always_ff @(posedge clock) begin
        dat_q[0] <= mem_q[idx];
        hbm_q[0] <= bus.hb_mask;
        lbm_q[0] <= bus.lb_mask;
        for (int i = 1; i < READ_LAT; i++) begin
            dat_q[i] <= dat_q[i-1];
            hbm_q[i] <= hbm_q[i-1];
            lbm_q[i] <= lbm_q[i-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (wr_acc || rd_acc) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Output gating uses the live pins, so an entry that emerges while the
    // host is not reading is simply lost rather than held.
    assign out_vld  = vld_q[LAST];
    assign rd_gate  = ~bus.chip_en & ~bus.oute & bus.wre;
    assign drive_hi = out_vld & ~hbm_q[LAST] & rd_gate;
    assign drive_lo = out_vld & ~lbm_q[LAST] & rd_gate;

    assign data[15:8] = drive_hi ? dat_q[LAST][15:8] : 8'hzz;
    assign data[7:0]  = drive_lo ? dat_q[LAST][7:0]  : 8'hzz;

    assign bus.rd_valid     = out_vld & rd_gate;
    assign bus.access_count = cnt_q;

`ifdef SRAM_RESPONDER_CONFLICT_EN
    logic err_q;
    logic err_d;
    logic would_drive;
    logic conflict;

    // would_drive is the output gate with wre ignored: the responder would
    // fight a host that is driving write data.
    assign would_drive = out_vld & ~bus.chip_en & ~bus.oute &
                         (~hbm_q[LAST] | ~lbm_q[LAST]);
    assign conflict    = (~bus.chip_en & ~bus.wre & ~bus.oute) |
                         (would_drive & ~bus.wre);

    always_comb begin
        err_d = err_q | conflict;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_conflict = err_q;
`else
    assign bus.err_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
//   Directed bench for sram_responder (DEPTH_LOG2=12, READ_LAT=2).
//   Each cycle spends its first half presenting the read gate (chip_en=0,
//   oute=0, wre=1) so any pipeline entry emerging then is visible, and its
//   second half presenting the command that the next edge samples. Expected
//   read data is queued when a read is issued; a monitor pops and compares
//   whenever rd_valid is seen. The data net is pulled up, so undriven bytes
//   read as 0xFF.
module tb_sram_responder;

    logic       clock;
    logic       reset;
    tri1 [15:0] data;
    logic       tb_drv;
    logic [15:0] tb_wd;

    sram_responder_if sif ();

    sram_responder #(
        .DEPTH_LOG2 (12),
        .READ_LAT   (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif.slave),
        .data  (data)
    );

    assign data = tb_drv ? tb_wd : 16'hzzzz;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        sif.chip_en = 1'b1;
        sif.wre     = 1'b1;
        sif.oute    = 1'b1;
        sif.hb_mask = 1'b1;
        sif.lb_mask = 1'b1;
        tb_drv      = 1'b0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic ce, input logic we, input logic oe,
                        input logic hb, input logic lb,
                        input logic [17:0] a, input logic [15:0] wd);
        sif.chip_en = 1'b0;
        sif.wre     = 1'b1;
        sif.oute    = 1'b0;
        tb_drv      = 1'b0;
        #5;
        sif.chip_en = ce;
        sif.wre     = we;
        sif.oute    = oe;
        sif.hb_mask = hb;
        sif.lb_mask = lb;
        sif.addr    = a;
        tb_wd       = wd;
        tb_drv      = ~ce & ~we;
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d,
                      input logic hb, input logic lb);
        step(1'b0, 1'b0, 1'b1, hb, lb, a, d);
    endtask

    task automatic rd(input logic [17:0] a, input logic hb, input logic lb,
                      input logic [15:0] exp, input bit push);
        if (push) exp_q.push_back(exp);
        step(1'b0, 1'b1, 1'b0, hb, lb, a, 16'h0000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0000);
        end
    endtask

    // Scoreboard monitor
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clock);
            #3;
            if (sif.rd_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rd_valid: got data %h, expected no read data", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        n_bad++;
                        $display("FAIL read_data: got %h, expected %h", data, e);
                    end
                end
            end else begin
                n_cmp++;
                if (data !== 16'hFFFF) begin
                    n_bad++;
                    $display("FAIL bus_float: got %h, expected %h", data, 16'hFFFF);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        sif.addr = 18'h0;
        tb_wd    = 16'h0;
        set_idle();
        #1 reset = 1'b0;
        #1;
        chk("rst_rd_valid", {31'd0, sif.rd_valid}, 32'd0);
        chk("rst_data", {16'd0, data}, 32'h0000FFFF);
        chk("rst_count", {16'd0, sif.access_count}, 32'd0);
        chk("rst_err", {31'd0, sif.err_conflict}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #5 reset = 1'b1;
        @(posedge clock);
        #1;

        // Address wrap: 0x01005 and 0x00005 share a word.
        wr(18'h01005, 16'h5A5A, 1'b0, 1'b0);
        rd(18'h00005, 1'b0, 1'b0, 16'h5A5A, 1'b1);
        idle(2);
        chk("count_after_wrap", {16'd0, sif.access_count}, 32'd2);

        wr(18'h00010, 16'hBEEF, 1'b0, 1'b0);
        rd(18'h00010, 1'b0, 1'b0, 16'hBEEF, 1'b1);
        idle(2);

        // High byte only.
        wr(18'h00010, 16'h1234, 1'b0, 1'b1);
        rd(18'h00010, 1'b0, 1'b0, 16'h12EF, 1'b1);
        idle(2);

        wr(18'h00001, 16'h0011, 1'b0, 1'b0);
        wr(18'h00002, 16'h0022, 1'b0, 1'b0);
        wr(18'h00003, 16'h0033, 1'b0, 1'b0);
        rd(18'h00001, 1'b0, 1'b0, 16'h0011, 1'b1);
        rd(18'h00002, 1'b0, 1'b0, 16'h0022, 1'b1);
        rd(18'h00003, 1'b0, 1'b0, 16'h0033, 1'b1);
        idle(2);

        // Read with high byte masked: upper byte floats to the pull-up.
        rd(18'h00010, 1'b1, 1'b0, 16'hFFEF, 1'b1);
        idle(2);

        // Top word of the array.
        wr(18'h3FFFF, 16'hC3A5, 1'b0, 1'b0);
        rd(18'h00FFF, 1'b0, 1'b0, 16'hC3A5, 1'b1);
        idle(2);

        // A write right behind a read does not disturb the captured data.
        rd(18'h00002, 1'b0, 1'b0, 16'h0022, 1'b1);
        wr(18'h00002, 16'hAAAA, 1'b0, 1'b0);
        rd(18'h00002, 1'b0, 1'b0, 16'hAAAA, 1'b1);
        idle(2);
        chk("count_total", {16'd0, sif.access_count}, 32'd18);
        chk("err_after_clean_traffic", {31'd0, sif.err_conflict}, 32'd0);

        // Reset while a read is in flight.
        rd(18'h00010, 1'b0, 1'b0, 16'h0000, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk("midrd_rd_valid", {31'd0, sif.rd_valid}, 32'd0);
        chk("midrd_data", {16'd0, data}, 32'h0000FFFF);
        chk("midrd_count", {16'd0, sif.access_count}, 32'd0);
        set_idle();
        @(posedge clock);
        @(posedge clock);
        #5 reset = 1'b1;
        @(posedge clock);
        #1;
        idle(3);
        rd(18'h00010, 1'b0, 1'b0, 16'h12EF, 1'b1);
        idle(2);
        chk("count_after_reset", {16'd0, sif.access_count}, 32'd1);

        // Write with oute also asserted: a protocol conflict.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00020, 16'h0000);
        idle(1);
`ifdef SRAM_RESPONDER_CONFLICT_EN
        chk("err_set", {31'd0, sif.err_conflict}, 32'd1);
        idle(3);
        chk("err_held", {31'd0, sif.err_conflict}, 32'd1);
`else
        chk("err_set", {31'd0, sif.err_conflict}, 32'd0);
        idle(3);
        chk("err_held", {31'd0, sif.err_conflict}, 32'd0);
`endif
        chk("count_conflict_write", {16'd0, sif.access_count}, 32'd2);
        #1 reset = 1'b0;
        #1;
        chk("err_cleared", {31'd0, sif.err_conflict}, 32'd0);
        @(posedge clock);
        #5 reset = 1'b1;
        @(posedge clock);
        #1;
        idle(2);

        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of stored 16-bit words.
REQ-002 SHALL have parameter READ_LAT, default 2, legal 1..4, meaning posedges from read sample to data drive.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low.
REQ-005 SHALL have port addr  input  18  word address.
REQ-006 SHALL have port data  inout  16  bidirectional data; high-Z when not driven.
REQ-007 SHALL have port wre  input  1  write enable, active-low.
REQ-008 SHALL have port oute  input  1  output enable, active-low.
REQ-009 SHALL have port hb_mask  input  1  high-byte enable (data[15:8]), active-low.
REQ-010 SHALL have port lb_mask  input  1  low-byte enable (data[7:0]), active-low.
REQ-011 SHALL have port chip_en  input  1  chip select, active-low.
REQ-012 SHALL have port rd_valid  output  1  high while read data is driven on data.
REQ-013 SHALL have port access_count  output  16  accepted reads plus writes, wrapping.
REQ-014 SHALL have port err_conflict  output  1  sticky protocol-error flag.

Function
REQ-015 Effective word index SHALL be addr[DEPTH_LOG2-1:0]; upper address bits ignored (wrap-around).
REQ-016 Write accepted at posedge when chip_en=0 and wre=0; oute ignored; write has priority over read.
REQ-017 On accepted write: high byte stored iff hb_mask=0, low byte iff lb_mask=0; other byte unchanged.
REQ-018 Read accepted at posedge when chip_en=0, wre=1, oute=0; word and both masks captured at that edge into a READ_LAT-deep pipeline.
REQ-019 Read captured at edge k SHALL return memory contents after all writes up to and including edge k-1.
REQ-020 Pipeline output entry SHALL become valid at edge k+READ_LAT-1 and remain for exactly one cycle.
REQ-021 data[15:8] driven iff output entry valid, captured hb_mask=0, and currently chip_en=0, oute=0, wre=1; data[7:0] likewise with lb_mask; otherwise each byte high-Z.
REQ-022 rd_valid SHALL equal output-entry-valid AND chip_en=0 AND oute=0 AND wre=1.
REQ-023 Back-to-back reads on consecutive edges SHALL produce data on consecutive cycles, in request order, no bubbles.
REQ-024 A write accepted while read entries are in flight SHALL NOT flush them; they emerge per REQ-020 and are gated per REQ-021.
REQ-025 access_count SHALL increment by 1 per accepted read or write, wrapping 0xFFFF->0x0000.
REQ-026 No access (chip_en=1, or wre=1 and oute=1) SHALL leave memory and access_count unchanged and insert an invalid pipeline entry.

Reset
REQ-027 reset=0 SHALL immediately clear all pipeline valid bits, access_count=0, err_conflict=0, rd_valid=0, data high-Z.
REQ-028 Reset SHALL NOT alter stored memory contents; content after power-up is undefined.
REQ-029 Reset asserted mid-read SHALL discard that read; no data driven after reset release without a new read.

Configuration
REQ-030 Macro SRAM_RESPONDER_CONFLICT_EN defined: err_conflict set at posedge when chip_en=0, wre=0, oute=0, or when data would be driven (REQ-021 gating ignoring wre) while wre=0; stays 1 until reset.
REQ-031 Macro SRAM_RESPONDER_CONFLICT_EN undefined: no checking logic; err_conflict tied 0.

Verification
REQ-032 Write 0xBEEF to addr 0x00010 (masks 0), read it with READ_LAT=2 -> data=0xBEEF, rd_valid=1 for exactly one cycle starting edge k+1.
REQ-033 Then write 0x1234 to 0x00010 with hb_mask=0, lb_mask=1 -> subsequent read returns 0x12EF.
REQ-034 DEPTH_LOG2=12: write 0x5A5A at 0x01005, read 0x00005 -> 0x5A5A; access_count=2.
REQ-035 Reads of 0x1,0x2,0x3 (preloaded 0x0011,0x0022,0x0033) on consecutive edges -> 0x0011,0x0022,0x0033 on consecutive cycles.
REQ-036 Assert reset one cycle after read sample -> data high-Z, rd_valid=0, access_count=0 at once; later read of same address returns prior contents.
REQ-037 With SRAM_RESPONDER_CONFLICT_EN: chip_en=0, wre=0, oute=0 for one edge -> err_conflict=1 held until reset; without macro stays 0.
